// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer:
// FSM states, instruction field geometry and the default halt opcode.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetchState_e;

  localparam int INSTR_W  = 32;
  localparam int ADDR_W   = 32;
  localparam int COUNT_W  = 16;

  localparam int OPCODE_W = 5;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 12;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 5;
  localparam int RS_LSB     = 10;
  localparam int RT_LSB     = 15;
  localparam int IMM_LSB    = 20;

  localparam logic [OPCODE_W-1:0] DEFAULT_HALT_OPCODE = 5'h1F;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Bundles the instruction-memory, redirect and issue signals of the sequencer.
// The master side is the sequencer; the slave side is memory plus consumer.
interface instr_fetch_sequencer_if;
  import fetch_pkg::*;

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_valid;
  logic [INSTR_W-1:0]  imem_data;

  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;

  logic                issue_valid;
  logic                issue_ready;
  logic [ADDR_W-1:0]   issue_pc;
  logic [OPCODE_W-1:0] issue_opcode;
  logic [REG_W-1:0]    issue_rd;
  logic [REG_W-1:0]    issue_rs;
  logic [REG_W-1:0]    issue_rt;
  logic [IMM_W-1:0]    issue_imm;

  logic                halted;
  logic [COUNT_W-1:0]  issue_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_data,
    input  redirect, redirect_pc,
    output issue_valid, issue_pc, issue_opcode, issue_rd, issue_rs, issue_rt, issue_imm,
    input  issue_ready,
    output halted, issue_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_data,
    output redirect, redirect_pc,
    input  issue_valid, issue_pc, issue_opcode, issue_rd, issue_rs, issue_rt, issue_imm,
    output issue_ready,
    input  halted, issue_count
  );

endinterface

// File: rtl/instr_fetch_sequencer_decoder.sv
// Purely combinational split of an instruction word into its issue fields.
module instruction_decoder
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr_i,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic [REG_W-1:0]    rd_o,
  output logic [REG_W-1:0]    rs_o,
  output logic [REG_W-1:0]    rt_o,
  output logic [IMM_W-1:0]    imm_o
);

  assign opcode_o = instr_i[OPCODE_LSB +: OPCODE_W];
  assign rd_o     = instr_i[RD_LSB     +: REG_W];
  assign rs_o     = instr_i[RS_LSB     +: REG_W];
  assign rt_o     = instr_i[RT_LSB     +: REG_W];
  assign imm_o    = instr_i[IMM_LSB    +: IMM_W];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: fetch, wait for memory,
// offer the decoded instruction, and stop for good on the halt opcode.
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]   RESET_PC    = 32'h0000_0000,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_sequencer_if.master bus
);

  fetchState_e          state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    ipc_q, ipc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 squash_q, squash_d;
  logic [COUNT_W-1:0]   issue_count_q, issue_count_d;

  logic [OPCODE_W-1:0]  decOpcode;
  logic [REG_W-1:0]     decRd;
  logic [REG_W-1:0]     decRs;
  logic [REG_W-1:0]     decRt;
  logic [IMM_W-1:0]     decImm;

  instruction_decoder u_decoder (
    .instr_i  (ir_q),
    .opcode_o (decOpcode),
    .rd_o     (decRd),
    .rs_o     (decRs),
    .rt_o     (decRt),
    .imm_o    (decImm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      ipc_q         <= '0;
      ir_q          <= '0;
      squash_q      <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ipc_q         <= ipc_d;
      ir_q          <= ir_d;
      squash_q      <= squash_d;
      issue_count_q <= issue_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ipc_d           = ipc_q;
    ir_d            = ir_q;
    squash_d        = squash_q;
    issue_count_d   = issue_count_q;
    bus.imem_req    = 1'b0;
    bus.issue_valid = 1'b0;
    bus.halted      = 1'b0;

    case (state_q)
      FETCH: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end else begin
          bus.imem_req = 1'b1;
          state_d      = WAIT;
        end
      end

      // A redirect while the request is in flight poisons its response,
      // whether that response arrives now or some cycles later.
      WAIT: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_valid) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            squash_d = 1'b1;
          end
        end else if (bus.imem_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            ir_d    = bus.imem_data;
            ipc_d   = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        bus.issue_valid = 1'b1;
        if (bus.issue_ready) begin
          issue_count_d = issue_count_q + 16'd1;
          if (bus.redirect) begin
            pc_d    = bus.redirect_pc;
            state_d = FETCH;
          end else if (decOpcode == HALT_OPCODE) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
          end
        end else if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
        end
      end

      HALT: begin
        bus.halted = 1'b1;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // The state register still holds its old value during the reset cycle.
    if (reset) begin
      bus.imem_req    = 1'b0;
      bus.issue_valid = 1'b0;
      bus.halted      = 1'b0;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.issue_pc     = ipc_q;
  assign bus.issue_opcode = decOpcode;
  assign bus.issue_rd     = decRd;
  assign bus.issue_rs     = decRs;
  assign bus.issue_rt     = decRt;
  assign bus.issue_imm    = decImm;
  assign bus.issue_count  = issue_count_q;

endmodule

// File: doc/instr_fetch_sequencer.md
INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 5'h1F, meaning the opcode that stops fetching once issued.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous reset, active-high.
REQ-006 imem_req  out  1  fetch request, one-cycle pulse.
REQ-007 imem_addr  out  32  fetch address, equals pc.
REQ-008 imem_valid  in  1  fetch response valid.
REQ-009 imem_data  in  32  fetched instruction word.
REQ-010 redirect  in  1  branch/jump redirect strobe.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 issue_valid  out  1  decoded instruction available.
REQ-013 issue_ready  in  1  consumer accepts issue.
REQ-014 issue_pc  out  32  address of the issued instruction.
REQ-015 issue_opcode, issue_rd, issue_rs, issue_rt  out  5 each  decoded fields.
REQ-016 issue_imm  out  12  decoded immediate.
REQ-017 halted  out  1  sequencer stopped.
REQ-018 issue_count  out  16  count of accepted issues.

Function
REQ-019 Instruction format SHALL be: opcode [4:0], rd [9:5], rs [14:10], rt [19:15], imm [31:20].
REQ-020 The FSM SHALL have four states: FETCH, WAIT, ISSUE, HALT.
REQ-021 FETCH: imem_req=1 and imem_addr=pc for one cycle, then go to WAIT; with redirect, imem_req=0, pc<=redirect_pc, stay in FETCH.
REQ-022 WAIT: imem_req=0; on imem_valid with no squash pending, latch IR<=imem_data and ipc<=pc, set pc<=pc+4 (mod 2^32), go to ISSUE.
REQ-023 Only one request SHALL be outstanding; imem_valid outside WAIT SHALL be ignored; memory latency is at least 1 cycle and unbounded.
REQ-024 Redirect in WAIT SHALL set pc<=redirect_pc and set squash; the next imem_valid SHALL be discarded, clearing squash and going to FETCH. Redirect coincident with imem_valid SHALL discard that data and go to FETCH.
REQ-025 ISSUE: issue_valid=1; fields decode IR; issue_pc=ipc; all outputs SHALL hold stable until issue_ready.
REQ-026 In ISSUE, issue_ready SHALL go to HALT if the opcode equals HALT_OPCODE, otherwise to FETCH; issue_count SHALL increment and wrap 16'hFFFF->0.
REQ-027 Redirect in ISSUE without issue_ready SHALL withdraw the instruction (issue_valid=0 next cycle, no count), set pc<=redirect_pc, and go to FETCH.
REQ-028 Redirect with issue_ready in the same cycle SHALL count the issue, set pc<=redirect_pc, and go to FETCH, even for a HALT opcode.
REQ-029 HALT: halted=1, all outputs idle, redirect and imem_valid ignored; exit only by reset.
REQ-030 Every valid-to-issue path SHALL add at least 1 cycle; the minimum loop FETCH->WAIT->ISSUE with 1-cycle memory and ready held high SHALL be 3 cycles per instruction.

Reset
REQ-031 On reset: state=FETCH, pc=RESET_PC, squash=0, IR=0, ipc=0, issue_count=0.
REQ-032 Outputs during the reset cycle SHALL be issue_valid=0, imem_req=0, halted=0.
REQ-033 The first cycle after reset SHALL have imem_req=1 and imem_addr=RESET_PC.
REQ-034 Reset mid-operation SHALL abandon any outstanding fetch; a late imem_valid SHALL be ignored because the state is FETCH.

Structure
REQ-035 Package fetch_pkg SHALL hold the state enum, the field width and position constants (5/5/5/5/12), and the default HALT_OPCODE.
REQ-036 A single instruction_decoder sub-module SHALL be instantiated on IR to produce the issue fields; the FSM, pc, IR, squash and counter SHALL be local.

Verification
REQ-037 Scenario: reset, 1-cycle memory returns 32'h0012_3441, ready=1 -> imem_addr 0 then 4; opcode=1, rd=2, rs=13, rt=4, imm=1; issue_count=1.
REQ-038 Scenario: ready held low 5 cycles in ISSUE -> issue_valid and fields stable for 5 cycles; count increments once on release.
REQ-039 Scenario: redirect to 32'h100 in WAIT, memory responds 3 cycles later -> response discarded; next imem_addr=32'h100; no issue from the old data.
REQ-040 Scenario: redirect coincident with issue_ready in ISSUE -> count+1; next fetch at redirect_pc.
REQ-041 Scenario: issue opcode 5'h1F accepted -> halted=1; no further imem_req; redirect ignored; reset restores fetch at RESET_PC.
REQ-042 Scenario: preload issue_count=16'hFFFF via 65535 issues, issue once more -> issue_count=0.
